// File: rtl/cache_defs_pkg.sv
// Shared instruction-cache definitions: default widths, line/word offset
// constants and the refill FSM state type.
package cache_defs;

  localparam int ADDR_W_DEF     = 32;
  localparam int LINE_W_DEF     = 128;
  localparam int BEAT_W_DEF     = 32;
  localparam int BEATS_PER_LINE = 4;
  localparam int WORD_OFF_LSB   = 2;
  localparam int WORD_OFF_MSB   = 3;
  localparam int LINE_OFF_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } type_icache_refill_states_e;

endpackage

// File: rtl/icache_refill_unit.sv
// Instruction-cache line refill: fetches four beats, assembles the line, pulses done.
// Optional ICACHE_CRITICAL_WORD_FIRST_EN: start at the missed word and expose it early.
//
// state | meaning
// IDLE  | waiting for a miss; line register holds the previous line
// FILL  | requesting beats, one slot written per ack
// DONE  | one-cycle line write enable to the datapath
module icache_refill_unit
  import cache_defs::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              refill_req_i,
  input  logic [ADDR_W-1:0] refill_addr_i,
  input  logic              flush_i,
  output logic              refill_busy_o,
  output logic              refill_done_o,
  output logic [LINE_W-1:0] refill_line_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [BEAT_W-1:0] mem_rdata_i
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  ,
  output logic              crit_valid_o,
  output logic [BEAT_W-1:0] crit_word_o
`endif
);

  type_icache_refill_states_e state_q;
  logic [1:0]                 beat_cnt_q;
  logic [1:0]                 start_q;
  logic [1:0]                 start_d;
  logic [1:0]                 word;
  logic [ADDR_W-1:LINE_OFF_W] tag_q;
  logic [LINE_W-1:0]          line_q;
  logic                       unused_addr_lsbs;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:LINE_OFF_W] tag,
                                                  input logic [1:0] w);
    return {tag, w, 2'b00};
  endfunction

  // Slot index wraps naturally in two bits, giving the modulo-4 beat order.
  assign word             = start_q + beat_cnt_q;
  assign refill_line_o    = line_q;
  assign unused_addr_lsbs = ^refill_addr_i[LINE_OFF_W-1:0];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign start_d      = refill_addr_i[WORD_OFF_MSB:WORD_OFF_LSB];
  assign crit_valid_o = (state_q == FILL) && (beat_cnt_q == 2'd0) && mem_ack_i && !flush_i;
  assign crit_word_o  = mem_rdata_i;
`else
  assign start_d      = 2'd0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      beat_cnt_q    <= 2'd0;
      start_q       <= 2'd0;
      tag_q         <= '0;
      line_q        <= '0;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= '0;
      refill_done_o <= 1'b0;
      refill_busy_o <= 1'b0;
    end else if (flush_i) begin
      // Flush wins over a same-cycle ack or request; that beat is dropped.
      state_q       <= IDLE;
      beat_cnt_q    <= 2'd0;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= '0;
      refill_done_o <= 1'b0;
      refill_busy_o <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          refill_done_o <= 1'b0;
          if (refill_req_i) begin
            state_q       <= FILL;
            tag_q         <= refill_addr_i[ADDR_W-1:LINE_OFF_W];
            start_q       <= start_d;
            beat_cnt_q    <= 2'd0;
            mem_req_o     <= 1'b1;
            mem_addr_o    <= beat_addr(refill_addr_i[ADDR_W-1:LINE_OFF_W], start_d);
            refill_busy_o <= 1'b1;
          end
        end
        FILL: begin
          if (mem_ack_i) begin
            line_q[32'(word)*BEAT_W +: BEAT_W] <= mem_rdata_i;
            beat_cnt_q <= beat_cnt_q + 2'd1;
            if (beat_cnt_q == 2'd3) begin
              state_q       <= DONE;
              mem_req_o     <= 1'b0;
              mem_addr_o    <= '0;
              refill_done_o <= 1'b1;
            end else begin
              mem_addr_o <= beat_addr(tag_q, word + 2'd1);
            end
          end
        end
        DONE: begin
          state_q       <= IDLE;
          refill_done_o <= 1'b0;
          refill_busy_o <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_refill_unit.md
ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32: fetch/memory byte-address width.
REQ-002 The block SHALL take parameter LINE_W, default 128: cache line width, equal to 4 beats.
REQ-003 The block SHALL take parameter BEAT_W, default 32: memory bus data width.
REQ-004 clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1: reset, synchronous and active-low.
REQ-006 refill_req_i  input  1: miss from the icache datapath; sampled only in IDLE.
REQ-007 refill_addr_i  input  ADDR_W: miss address; bits [3:2] are the word offset.
REQ-008 flush_i  input  1: abort any refill.
REQ-009 refill_busy_o  output  1: high in any state other than IDLE.
REQ-010 refill_done_o  output  1: one-cycle pulse; drives the datapath line write enable.
REQ-011 refill_line_o  output  LINE_W: assembled line; word i at bits [32i+31:32i].
REQ-012 mem_req_o  output  1: beat read request, held until acknowledged.
REQ-013 mem_addr_o  output  ADDR_W: word-aligned beat address.
REQ-014 mem_ack_i  input  1: beat accepted; mem_rdata_i is valid in the same cycle.
REQ-015 mem_rdata_i  input  BEAT_W: beat data.

Function
REQ-016 The FSM SHALL have states IDLE, FILL and DONE.
REQ-017 IDLE->FILL on refill_req_i=1 and flush_i=0, latching line base {refill_addr_i[ADDR_W-1:4],4'b0} and the start offset; the beat counter is cleared.
REQ-018 In FILL, mem_req_o=1 and mem_addr_o=base+4*word, where word=(start+beat_cnt) mod 4.
REQ-019 On mem_ack_i in FILL, mem_rdata_i SHALL be written into line slot word and beat_cnt SHALL increment by 1, 2 bits wide.
REQ-020 An ack on beat_cnt=3 SHALL move the FSM to DONE; DONE SHALL assert refill_done_o for exactly one cycle and return to IDLE.
REQ-021 refill_line_o SHALL hold the last assembled line until the next refill writes over it.
REQ-022 Latency with zero-wait memory: request accepted at cycle 0, beats at cycles 1-4, refill_done_o at cycle 5.
REQ-023 refill_req_i SHALL be ignored while busy, and a new request SHALL be accepted no earlier than the cycle after DONE.
REQ-024 flush_i=1 in any state SHALL force IDLE on the next edge with no done pulse; flush has priority over a same-cycle ack or request, and that beat is discarded.
REQ-025 Memory stalls (mem_ack_i=0) SHALL hold mem_req_o, mem_addr_o and all state unchanged, with no timeout.

Reset
REQ-026 With rst_ni=0 at an edge: state=IDLE, beat_cnt=0, line register=0, mem_req_o=0, mem_addr_o=0, refill_done_o=0, refill_busy_o=0.
REQ-027 Reset in the middle of a refill SHALL abandon it with no done pulse; reset has priority over flush.

Configuration
REQ-028 Macro ICACHE_CRITICAL_WORD_FIRST_EN: when defined, start=refill_addr_i[3:2], the beat order wraps modulo 4, and output crit_valid_o (1 bit, a one-cycle pulse) with crit_word_o (BEAT_W) is presented in the cycle of the first ack.
REQ-029 When ICACHE_CRITICAL_WORD_FIRST_EN is undefined, start=0, the order is 0,1,2,3, and crit_valid_o/crit_word_o do not exist.

Structure
REQ-030 ADDR_W/LINE_W/BEAT_W defaults, the offset-bit constants and the state enum type_icache_refill_states_e SHALL live in the shared cache_defs package.
REQ-031 The block SHALL be a single module with no sub-module; the line register is updated per slot.

Verification
REQ-032 Zero-wait refill at 0x0000_1008 with beats 0xA0..0xA3 -> mem_addr_o 0x1000,0x1004,0x1008,0x100C; refill_done_o at cycle 5; line=0x000000A3_000000A2_000000A1_000000A0.
REQ-033 Same request with ICACHE_CRITICAL_WORD_FIRST_EN -> addresses 0x1008,0x100C,0x1000,0x1004; crit_valid_o at cycle 1 with the first beat; slots placed by address.
REQ-034 Random stalls (0-3 cycles per beat) -> mem_req_o/mem_addr_o stable while ack=0; same final line; exactly one done pulse.
REQ-035 flush_i together with the third ack -> IDLE next cycle, no done pulse, mem_req_o=0; a new request then completes correctly.
REQ-036 rst_ni=0 after beat 2, and refill_req_i pulsed during FILL -> all REQ-026 values after reset; the extra request never starts a second refill.
